// File: rtl/mac_operand_feeder_if.sv
// rtl/mac_operand_feeder_if.sv - load, MAC-controller and result signals of mac_operand_feeder
interface mac_operand_feeder_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5,
  parameter int ACC_W  = 21
);
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_x;
  logic [DATA_W-1:0] wr_w;
  logic              load_done;
  logic              ld_ready;
  logic              mac_start;
  logic [IDX_W-1:0]  mac_i;
  logic              mac_done;
  logic              mac_ld_buf;
  logic [ACC_W-1:0]  acc_in;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] w_out;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_x, wr_w, load_done, mac_i, mac_done, mac_ld_buf, acc_in, res_ready,
    input  ld_ready, mac_start, x_out, w_out, res_valid, res_data, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_w, load_done, mac_i, mac_done, mac_ld_buf, acc_in, res_ready,
    output ld_ready, mac_start, x_out, w_out, res_valid, res_data, err
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand buffer and result holder for the MAC controller
// Optional watchdog: define MAC_OPERAND_FEEDER_TIMEOUT_EN.
module mac_operand_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int IDX_W   = 5,
  parameter int ACC_W   = 21,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  mac_operand_feeder_if.slave bus
);

  typedef enum logic [1:0] {LOAD, ARM, RUN, HOLD} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] xmem [DEPTH];
  logic [DATA_W-1:0] wmem [DEPTH];
  logic              mac_start_q;
  logic              res_valid_q;
  logic [ACC_W-1:0]  res_data_q;
  logic              timeout_hit;

  // Buffer is deliberately left out of reset so a partial rewrite can follow a run.
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && bus.wr_en) begin
      xmem[bus.wr_addr] <= bus.wr_x;
      wmem[bus.wr_addr] <= bus.wr_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (bus.load_done)                 state_nxt = ARM;
      ARM:  if (bus.mac_ld_buf)                state_nxt = RUN;
      RUN:  if (bus.mac_done || timeout_hit)   state_nxt = HOLD;
      HOLD: if (bus.res_ready)                 state_nxt = LOAD;
      default:                                 state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mac_start_q <= (state == ARM) && bus.mac_ld_buf;
      if (state == RUN && bus.mac_done) begin
        res_data_q  <= bus.acc_in;
        res_valid_q <= 1'b1;
      end else if (state == RUN && timeout_hit) begin
        res_data_q  <= '0;
        res_valid_q <= 1'b1;
      end else if (state == HOLD && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Counter sits at zero outside RUN, so it restarts on every RUN entry.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                                              err_q <= 1'b0;
    else if (state == RUN && !bus.mac_done && timeout_hit) err_q <= 1'b1;
    else if (state == HOLD && bus.res_ready)              err_q <= 1'b0;
  end

  assign bus.err = err_q;
`else
  wire unused_timeout = |TIMEOUT;
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.ld_ready  = (state == LOAD);
  assign bus.mac_start = mac_start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.x_out     = (state == RUN) ? xmem[bus.mac_i] : '0;
  assign bus.w_out     = (state == RUN) ? wmem[bus.mac_i] : '0;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mac_operand_feeder_if #(.DATA_W(8), .IDX_W(5), .ACC_W(21)) bus ();

  mac_operand_feeder #(
    .DATA_W(8), .DEPTH(32), .IDX_W(5), .ACC_W(21), .TIMEOUT(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_x = '0; bus.wr_w = '0;
    bus.load_done = 1'b0; bus.mac_i = '0; bus.mac_done = 1'b0;
    bus.mac_ld_buf = 1'b0; bus.acc_in = '0; bus.res_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_mac_start", 32'(bus.mac_start), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_x_out", 32'(bus.x_out), 32'd0);

    for (int k = 0; k < 32; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'(k); bus.wr_x = 8'(k); bus.wr_w = 8'd1;
      step();
    end
    bus.wr_en = 1'b0; bus.load_done = 1'b1; bus.mac_ld_buf = 1'b1;
    step();
    bus.load_done = 1'b0;
    check("arm_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("arm_no_start", 32'(bus.mac_start), 32'd0);
    step();
    check("start_pulse", 32'(bus.mac_start), 32'd1);
    bus.mac_ld_buf = 1'b0;
    step();
    check("start_one_cycle", 32'(bus.mac_start), 32'd0);

    for (int i = 0; i < 32; i++) begin
      bus.mac_i = 5'(i);
      #1;
      check($sformatf("x_out_%0d", i), 32'(bus.x_out), 32'(i));
      check($sformatf("w_out_%0d", i), 32'(bus.w_out), 32'd1);
      step();
    end

    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_x = 8'hAA; bus.wr_w = 8'hAA;
    step();
    bus.wr_en = 1'b0; bus.mac_i = 5'd3;
    #1;
    check("run_write_ignored", 32'(bus.x_out), 32'd3);

    bus.acc_in = 21'd496; bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0; bus.acc_in = 21'd7;
    check("res_valid_set", 32'(bus.res_valid), 32'd1);
    check("res_data_496", 32'(bus.res_data), 32'd496);
    check("hold_x_zero", 32'(bus.x_out), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_data", 32'(bus.res_data), 32'd496);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("accept_valid_low", 32'(bus.res_valid), 32'd0);
    check("accept_ld_ready", 32'(bus.ld_ready), 32'd1);

    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_x = 8'h55; bus.wr_w = 8'd2;
    bus.load_done = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.load_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("stall_no_start", 32'(bus.mac_start), 32'd0);
      check("stall_ld_ready", 32'(bus.ld_ready), 32'd0);
      step();
    end
    bus.mac_ld_buf = 1'b1;
    step();
    bus.mac_ld_buf = 1'b0;
    check("stall_start", 32'(bus.mac_start), 32'd1);
    bus.mac_i = 5'd5;
    #1;
    check("simul_wr_x5", 32'(bus.x_out), 32'h55);
    check("simul_wr_w5", 32'(bus.w_out), 32'd2);
    bus.mac_i = 5'd3;
    #1;
    check("retained_x3", 32'(bus.x_out), 32'd3);

    bus.acc_in = 21'd123; bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0;
    check("res_data_123", 32'(bus.res_data), 32'd123);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0; bus.mac_ld_buf = 1'b1;
    step();
    bus.mac_ld_buf = 1'b0;
    for (int c = 0; c < 63; c++) step();
    check("wd_pre_valid", 32'(bus.res_valid), 32'd0);
    step();
`ifdef MAC_OPERAND_FEEDER_TIMEOUT_EN
    check("wd_valid", 32'(bus.res_valid), 32'd1);
    check("wd_data", 32'(bus.res_data), 32'd0);
    check("wd_err", 32'(bus.err), 32'd1);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("wd_err_clear", 32'(bus.err), 32'd0);
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0; bus.mac_ld_buf = 1'b1;
    step();
    bus.mac_ld_buf = 1'b0;
`else
    check("nowd_valid", 32'(bus.res_valid), 32'd0);
    check("nowd_err", 32'(bus.err), 32'd0);
`endif
    bus.mac_i = 5'd5;
    #1;
    check("pre_rst_x5", 32'(bus.x_out), 32'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_mac_start", 32'(bus.mac_start), 32'd0);
    check("midrst_x_out", 32'(bus.x_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Operand-side counterpart of the MAC controller.
- Holds one 32-entry input/weight vector pair, loaded through a write port.
- Pulses the controller's start, then serves x/w operands indexed by the controller's i counter.
- Captures the accumulator result on the controller's done and presents it downstream with a valid/ready handshake.

Parameters:
- DATA_W, 8, width of each x and w operand
- DEPTH, 32, vector length / number of buffer entries
- IDX_W, 5, index width (log2 DEPTH)
- ACC_W, 21, accumulator/result width (2*DATA_W + IDX_W)
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  buffer write strobe
- wr_addr  input  IDX_W  buffer write address
- wr_x  input  DATA_W  input operand to store
- wr_w  input  DATA_W  weight operand to store
- load_done  input  1  pulse: vector fully loaded
- ld_ready  output  1  high while writes are accepted
- mac_start  output  1  one-cycle start pulse to the MAC controller
- mac_i  input  IDX_W  operand index from the MAC controller
- mac_done  input  1  MAC controller done pulse
- mac_ld_buf  input  1  MAC controller idle indication
- acc_in  input  ACC_W  accumulator value from the MAC datapath
- x_out  output  DATA_W  operand x[mac_i]
- w_out  output  DATA_W  operand w[mac_i]
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts result
- res_data  output  ACC_W  captured result
- err  output  1  watchdog error flag

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous and active-high.
- Reset values:
  - state = LOAD, ld_ready = 1.
  - mac_start, res_valid, err = 0; res_data = 0.
  - Buffer contents are not reset.
- LOAD:
  - ld_ready = 1.
  - wr_en writes xmem[wr_addr] = wr_x and wmem[wr_addr] = wr_w at the clock edge. The last write to an address wins.
  - load_done moves to ARM. If wr_en and load_done arrive in the same cycle, the write is performed, then the transition.
- ARM:
  - ld_ready = 0.
  - Waits for mac_ld_buf = 1.
  - In the first cycle with mac_ld_buf = 1, mac_start = 1 (registered, exactly one cycle), then moves to RUN.
- RUN:
  - x_out = xmem[mac_i] and w_out = wmem[mac_i], combinational with zero latency, tracking mac_i every cycle.
  - On mac_done = 1: res_data <= acc_in, res_valid <= 1, move to HOLD.
- HOLD:
  - res_valid = 1 and res_data is stable until res_ready = 1.
  - On res_valid & res_ready: res_valid <= 0, err <= 0, move to LOAD. The buffer is retained, so a partial rewrite is allowed.
- Operand outputs outside RUN: x_out = w_out = 0.
- Ignored inputs:
  - wr_en outside LOAD is ignored; the buffer is unchanged.
  - load_done outside LOAD is ignored.
  - mac_done outside RUN is ignored.
- Index range: mac_i is used modulo DEPTH, so no out-of-range access occurs.
- Reset mid-operation: rst in any state forces the reset values next cycle. A pending mac_start is dropped, and the buffer is kept.
- Result handshake: res_ready while res_valid = 0 has no effect.

Optional Feature:
- Macro: MAC_OPERAND_FEEDER_TIMEOUT_EN.
- When defined:
  - A counter clears on RUN entry and increments every RUN cycle.
  - If it reaches TIMEOUT without mac_done: res_data <= 0, err <= 1, res_valid <= 1, move to HOLD.
  - err clears on result acceptance or rst.
- When not defined: no counter exists, err is tied to 0, and RUN waits for mac_done indefinitely.

Test Plan:
- Load and single run:
  - Stimulus: reset; write x[k] = k, w[k] = 1 for k = 0..31; pulse load_done; hold mac_ld_buf = 1.
  - Response: exactly one mac_start pulse one cycle after entering ARM.
- Operand serving:
  - Stimulus: in RUN, sweep mac_i 0..31.
  - Response: x_out = mac_i and w_out = 1 in the same cycle, each index.
- Result capture:
  - Stimulus: acc_in = 496, pulse mac_done.
  - Response: next cycle res_valid = 1 and res_data = 496. With res_ready held low for 5 cycles, the output stays stable. Raising res_ready gives res_valid = 0 and ld_ready = 1 next cycle.
- Ignored writes and simultaneous write/load_done:
  - Stimulus: wr_en at address 3 with value 0xAA during RUN.
  - Response: x[3] remains 3.
  - Stimulus: wr_en at address 5 with value 0x55 together with load_done in LOAD.
  - Response: x[5] = 0x55 is served at mac_i = 5.
- ARM stall and reset:
  - Stimulus: mac_ld_buf = 0 for 10 cycles in ARM.
  - Response: no mac_start until mac_ld_buf rises.
  - Stimulus: rst asserted mid-RUN.
  - Response: state LOAD, res_valid = 0, mac_start = 0, x_out = 0 next cycle.
- Watchdog (MAC_OPERAND_FEEDER_TIMEOUT_EN defined):
  - Stimulus: no mac_done for 64 RUN cycles.
  - Response: res_valid = 1, res_data = 0, err = 1.
  - Without the macro: err stays 0 and res_valid stays 0.
